// File: rtl/thread_msg_engine.sv
// thread_msg_engine: issues FORK/STOP requests to the dispatcher and waits (bounded) for the done reply.
// Optional resend-on-timeout is enabled by defining THREAD_MSG_RETRY_EN.

`ifndef THREAD_HEADER_SPACE
`define THREAD_HEADER_SPACE 16
`endif
`ifndef CMD_FORK
`define CMD_FORK 4'h1
`endif
`ifndef CMD_STOP
`define CMD_STOP 4'h2
`endif
`ifndef CPU_R_FORK_THRD
`define CPU_R_FORK_THRD 8'h21
`endif
`ifndef CPU_R_STOP_THRD
`define CPU_R_STOP_THRD 8'h22
`endif
`ifndef CPU_R_FORK_DONE
`define CPU_R_FORK_DONE 8'h31
`endif
`ifndef CPU_R_STOP_DONE
`define CPU_R_STOP_DONE 8'h32
`endif

module thread_msg_engine #(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 32,
  parameter int          MSG_W     = 8,
  parameter int unsigned HDR_SPACE = `THREAD_HEADER_SPACE,
  parameter int          TMO_CYC   = 255,
  parameter int          MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_oe,
  input  logic              start,
  input  logic [3:0]        cmd_code,
  input  logic [DATA_W-1:0] src0,
  input  logic [DATA_W-1:0] src1,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] base_addr_data,
  input  logic              disp_online,
  input  logic [MSG_W-1:0]  cpu_msg_in,
  output logic [MSG_W-1:0]  cpu_msg_out,
  output logic              cpu_msg_pulse,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              next_state,
  output logic              err,
  output logic              busy
);

  localparam int TMO_W = $clog2(TMO_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_DONE,
    S_FAIL
`ifdef THREAD_MSG_RETRY_EN
    , S_RETRY
`endif
  } state_t;

  state_t state_reg, state_next;

  logic [TMO_W-1:0]  tmo_cnt_reg;
  logic [MSG_W-1:0]  msg_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic              stop_reg;
  logic              armed_reg;

`ifdef THREAD_MSG_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RETRY_W-1:0] retry_cnt_reg;
`endif

  logic              cmd_fork, cmd_stop, launch, reply_match, tmo_last;
  logic [ADDR_W-1:0] hdr_a;
  logic [DATA_W-1:0] hdr_d, bad_d;
  logic [MSG_W-1:0]  launch_msg;
  logic [ADDR_W-1:0] launch_addr;
  logic [DATA_W-1:0] launch_data;

  always_comb begin
    cmd_fork    = (cmd_code == `CMD_FORK);
    cmd_stop    = (cmd_code == `CMD_STOP);
    // armed_reg blocks relaunch on a start level still held from the previous command
    launch      = start & disp_online & (cmd_fork | cmd_stop) & armed_reg;
    hdr_a       = ADDR_W'(HDR_SPACE);
    hdr_d       = DATA_W'(HDR_SPACE);
    bad_d       = DATA_W'(base_addr_data);
    launch_msg  = MSG_W'(`CPU_R_FORK_THRD);
    launch_addr = ADDR_W'(src0) + base_addr_data;
    launch_data = src1 + bad_d;
    if (cmd_stop) begin
      launch_msg  = MSG_W'(`CPU_R_STOP_THRD);
      launch_addr = ADDR_W'(src0) + base_addr - hdr_a;
      launch_data = (src1 == '0) ? (bad_d - hdr_d) : (src1 + bad_d - hdr_d);
    end
    reply_match = stop_reg ? (cpu_msg_in == MSG_W'(`CPU_R_STOP_DONE))
                           : (cpu_msg_in == MSG_W'(`CPU_R_FORK_DONE));
    tmo_last    = (tmo_cnt_reg == TMO_W'(TMO_CYC - 1));
  end

  always_ff @(posedge clk) begin
    if (clk_oe) begin
      if (rst) state_reg <= S_IDLE;
      else     state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (launch) state_next = S_SEND;
      S_SEND: state_next = S_WAIT;
      S_WAIT: begin
        // a matching reply beats both dispatcher loss and the timeout edge
        if (reply_match)       state_next = S_DONE;
        else if (!disp_online) state_next = S_FAIL;
        else if (tmo_last) begin
`ifdef THREAD_MSG_RETRY_EN
          state_next = (retry_cnt_reg < RETRY_W'(MAX_RETRY)) ? S_RETRY : S_FAIL;
`else
          state_next = S_FAIL;
`endif
        end
      end
      S_DONE: state_next = S_IDLE;
      S_FAIL: state_next = S_IDLE;
`ifdef THREAD_MSG_RETRY_EN
      S_RETRY: state_next = S_SEND;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_msg_pulse = 1'b0;
    cpu_msg_out   = '0;
    addr_out      = '0;
    data_out      = '0;
    next_state    = 1'b0;
    err           = 1'b0;
    busy          = (state_reg != S_IDLE);
    case (state_reg)
      S_SEND: begin
        cpu_msg_pulse = 1'b1;
        cpu_msg_out   = msg_reg;
        addr_out      = addr_reg;
        data_out      = data_reg;
      end
      S_DONE:  next_state = clk_oe;
      S_FAIL:  err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clk_oe) begin
      if (rst) begin
        tmo_cnt_reg <= '0;
        msg_reg     <= '0;
        addr_reg    <= '0;
        data_reg    <= '0;
        stop_reg    <= 1'b0;
        armed_reg   <= 1'b1;
`ifdef THREAD_MSG_RETRY_EN
        retry_cnt_reg <= '0;
`endif
      end else begin
        if (!start)                armed_reg <= 1'b1;
        else if (state_reg == S_DONE) armed_reg <= 1'b0;

        if (state_reg == S_IDLE && launch) begin
          msg_reg  <= launch_msg;
          addr_reg <= launch_addr;
          data_reg <= launch_data;
          stop_reg <= cmd_stop;
`ifdef THREAD_MSG_RETRY_EN
          retry_cnt_reg <= '0;
`endif
        end

        if (state_reg == S_SEND)      tmo_cnt_reg <= '0;
        else if (state_reg == S_WAIT) tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);

`ifdef THREAD_MSG_RETRY_EN
        if (state_reg == S_RETRY) begin
          retry_cnt_reg <= retry_cnt_reg + RETRY_W'(1);
          tmo_cnt_reg   <= '0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_thread_msg_engine.sv
// Self-checking bench for thread_msg_engine: directed spec scenarios followed by randomized traffic,
// all compared cycle-by-cycle against a transaction-level reference model.

`ifndef THREAD_HEADER_SPACE
`define THREAD_HEADER_SPACE 16
`endif
`ifndef CMD_FORK
`define CMD_FORK 4'h1
`endif
`ifndef CMD_STOP
`define CMD_STOP 4'h2
`endif
`ifndef CPU_R_FORK_THRD
`define CPU_R_FORK_THRD 8'h21
`endif
`ifndef CPU_R_STOP_THRD
`define CPU_R_STOP_THRD 8'h22
`endif
`ifndef CPU_R_FORK_DONE
`define CPU_R_FORK_DONE 8'h31
`endif
`ifndef CPU_R_STOP_DONE
`define CPU_R_STOP_DONE 8'h32
`endif

module tb_thread_msg_engine;

  localparam int TMO  = 8;
  localparam int MAXR = 3;
  localparam logic [31:0] HDR = 32'h10;
`ifdef THREAD_MSG_RETRY_EN
  localparam int RESENDS = MAXR;
`else
  localparam int RESENDS = 0;
`endif

  localparam logic [3:0] FORK      = `CMD_FORK;
  localparam logic [3:0] STOP      = `CMD_STOP;
  localparam logic [7:0] FORK_THRD = `CPU_R_FORK_THRD;
  localparam logic [7:0] STOP_THRD = `CPU_R_STOP_THRD;
  localparam logic [7:0] FORK_DONE = `CPU_R_FORK_DONE;
  localparam logic [7:0] STOP_DONE = `CPU_R_STOP_DONE;

  logic        clk = 1'b0;
  logic        rst = 1'b0, clk_oe = 1'b1, start = 1'b0, disp_online = 1'b1;
  logic [3:0]  cmd_code = '0;
  logic [31:0] src0 = '0, src1 = '0, base_addr = '0, base_addr_data = '0;
  logic [7:0]  cpu_msg_in = '0;
  logic [7:0]  cpu_msg_out;
  logic        cpu_msg_pulse, next_state, err, busy;
  logic [31:0] addr_out, data_out;

  always #5 clk = ~clk;

  thread_msg_engine #(
    .DATA_W(32), .ADDR_W(32), .MSG_W(8), .HDR_SPACE(32'h10), .TMO_CYC(TMO), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst(rst), .clk_oe(clk_oe), .start(start), .cmd_code(cmd_code),
    .src0(src0), .src1(src1), .base_addr(base_addr), .base_addr_data(base_addr_data),
    .disp_online(disp_online), .cpu_msg_in(cpu_msg_in), .cpu_msg_out(cpu_msg_out),
    .cpu_msg_pulse(cpu_msg_pulse), .addr_out(addr_out), .data_out(data_out),
    .next_state(next_state), .err(err), .busy(busy)
  );

  int n_tests = 0, n_fail = 0;
  int pulses = 0, errs = 0, nexts = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: request phase plus remaining-wait and remaining-resend budgets.
  typedef enum int {M_IDLE, M_SEND, M_WAIT, M_DONE, M_FAIL, M_RETRY} mphase_t;
  mphase_t     ph = M_IDLE;
  int          wait_left = 0, resends_left = 0;
  bit          armed = 1'b1, m_stop = 1'b0;
  logic [7:0]  m_msg = '0;
  logic [31:0] m_addr = '0, m_data = '0;

  task automatic model_step();
    bit was_done;
    if (!clk_oe) return;
    if (rst) begin
      ph = M_IDLE; armed = 1'b1; wait_left = 0; resends_left = 0;
      return;
    end
    was_done = (ph == M_DONE);
    case (ph)
      M_IDLE: if (start && disp_online && armed && (cmd_code == FORK || cmd_code == STOP)) begin
        m_stop = (cmd_code == STOP);
        if (m_stop) begin
          m_msg  = STOP_THRD;
          m_addr = src0 + base_addr - HDR;
          m_data = (src1 == 0) ? base_addr_data - HDR : src1 + base_addr_data - HDR;
        end else begin
          m_msg  = FORK_THRD;
          m_addr = src0 + base_addr_data;
          m_data = src1 + base_addr_data;
        end
        resends_left = RESENDS;
        ph = M_SEND;
      end
      M_SEND: begin ph = M_WAIT; wait_left = TMO; end
      M_WAIT: begin
        if (cpu_msg_in == (m_stop ? STOP_DONE : FORK_DONE)) ph = M_DONE;
        else if (!disp_online) ph = M_FAIL;
        else begin
          wait_left--;
          if (wait_left == 0) ph = (resends_left > 0) ? M_RETRY : M_FAIL;
        end
      end
      M_RETRY: begin resends_left--; ph = M_SEND; end
      default: ph = M_IDLE;
    endcase
    if (!start) armed = 1'b1;
    else if (was_done) armed = 1'b0;
  endtask

  task automatic check_outputs();
    bit in_send;
    in_send = (ph == M_SEND);
    check("pulse", cpu_msg_pulse, in_send);
    check("msg_out", cpu_msg_out, in_send ? m_msg : 8'h0);
    check("addr_out", addr_out, in_send ? m_addr : 32'h0);
    check("data_out", data_out, in_send ? m_data : 32'h0);
    check("next_state", next_state, (ph == M_DONE) && clk_oe);
    check("err", err, ph == M_FAIL);
    check("busy", busy, ph != M_IDLE);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
    pulses += int'(cpu_msg_pulse);
    errs   += int'(err);
    nexts  += int'(next_state);
  endtask

  initial begin
    // reset
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    check("rst_busy", busy, 1'b0);

    // FORK example
    base_addr_data = 32'h100; base_addr = 32'h0; src0 = 32'h20; src1 = 32'h40;
    cmd_code = FORK; start = 1'b1; tick();
    check("fork_pulse", cpu_msg_pulse, 1'b1);
    check("fork_addr", addr_out, 32'h120);
    check("fork_data", data_out, 32'h140);
    check("fork_msg", cpu_msg_out, FORK_THRD);
    start = 1'b0; tick(); tick();
    cpu_msg_in = FORK_DONE; tick(); cpu_msg_in = '0;
    check("fork_next", next_state, 1'b1);
    check("fork_err", err, 1'b0);
    tick();

    // STOP with src1 == 0
    base_addr = 32'h200; base_addr_data = 32'h300; src0 = 32'h4; src1 = 32'h0;
    cmd_code = STOP; start = 1'b1; tick();
    check("stop_addr", addr_out, 32'h1F4);
    check("stop_data", data_out, 32'h2F0);
    check("stop_msg", cpu_msg_out, STOP_THRD);
    start = 1'b0; cpu_msg_in = STOP_DONE; tick(); tick(); cpu_msg_in = '0;
    check("stop_next", next_state, 1'b1);
    tick();

    // no reply: timeout (with resends when enabled)
    pulses = 0; errs = 0; nexts = 0;
    cmd_code = FORK; start = 1'b1; tick(); start = 1'b0;
    repeat (12 * (RESENDS + 1)) tick();
    check("tmo_pulses", pulses, RESENDS + 1);
    check("tmo_errs", errs, 1);
    check("tmo_nexts", nexts, 0);

    // dispatcher offline holds off the launch
    disp_online = 1'b0; start = 1'b1; tick();
    check("offline_busy", busy, 1'b0);
    check("offline_pulse", cpu_msg_pulse, 1'b0);
    disp_online = 1'b1; tick();
    check("online_pulse", cpu_msg_pulse, 1'b1);
    start = 1'b0; tick(); tick();

    // reset in WAIT, late reply must not complete anything
    rst = 1'b1; tick(); rst = 1'b0;
    check("rstwait_busy", busy, 1'b0);
    nexts = 0; cpu_msg_in = FORK_DONE; repeat (3) tick(); cpu_msg_in = '0;
    check("rstwait_nonext", nexts, 0);

    // clock enable low during WAIT freezes the timeout; reply lands on the last wait cycle
    start = 1'b1; tick(); start = 1'b0; tick(); tick();
    clk_oe = 1'b0; nexts = 0; repeat (5) tick();
    check("oe_frozen_next", nexts, 0);
    check("oe_frozen_busy", busy, 1'b1);
    clk_oe = 1'b1; repeat (6) tick();
    cpu_msg_in = FORK_DONE; tick(); cpu_msg_in = '0;
    check("oe_next", next_state, 1'b1);
    tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      rst         = ($urandom_range(0, 99) == 0);
      clk_oe      = ($urandom_range(0, 7) != 0);
      start       = ($urandom_range(0, 3) != 0);
      disp_online = ($urandom_range(0, 19) != 0);
      r = $urandom_range(0, 2);
      cmd_code    = (r == 0) ? FORK : (r == 1) ? STOP : 4'($urandom);
      src0        = $urandom;
      src1        = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      base_addr   = $urandom;
      base_addr_data = $urandom;
      r = $urandom_range(0, 5);
      cpu_msg_in  = (r == 0) ? FORK_DONE : (r == 1) ? STOP_DONE : 8'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
